// File: rtl/spi_adc_pkg.sv
// Shared widths, SAR state encoding and synchroniser idle values for the SPI SAR ADC responder.
package spi_adc_pkg;
   localparam int DATA_W      = 12;
   localparam int FRAME_W     = 16;
   localparam int SYNC_STAGES = 2;

   localparam logic [1:0] SAR_IDLE    = 2'd0;
   localparam logic [1:0] SAR_SAMPLE  = 2'd1;
   localparam logic [1:0] SAR_CONVERT = 2'd2;
   localparam logic [1:0] SAR_DONE    = 2'd3;

   localparam logic SCLK_IDLE = 1'b0;
   localparam logic CS_N_IDLE = 1'b1;
   localparam logic MOSI_IDLE = 1'b0;
endpackage

// File: rtl/sar_core.sv
// Successive-approximation FSM: start -> sample -> DATA_W trial cycles -> done.
// Latency: DATA_W+2 clk from start to eoc; start is ignored unless idle.
module sar_core
   import spi_adc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] held_in,
   output logic              busy,
   output logic              eoc,
   output logic [DATA_W-1:0] code
);

   localparam int IDX_W = $clog2(DATA_W);

   logic [1:0]        state;
   logic [DATA_W-1:0] held;
   logic [DATA_W-1:0] sar;
   logic [DATA_W-1:0] trial;
   logic [IDX_W-1:0]  idx;

   always_comb begin
      trial = sar | (DATA_W'(1) << idx);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SAR_IDLE;
         held  <= '0;
         sar   <= '0;
         idx   <= '0;
         busy  <= 1'b0;
         eoc   <= 1'b0;
         code  <= '0;
      end else begin
         eoc <= 1'b0;
         case (state)
            SAR_IDLE: begin
               if (start) state <= SAR_SAMPLE;
            end
            SAR_SAMPLE: begin
               held  <= held_in;
               sar   <= '0;
               idx   <= IDX_W'(DATA_W - 1);
               busy  <= 1'b1;
               state <= SAR_CONVERT;
            end
            SAR_CONVERT: begin
               if (held >= trial) sar <= trial;
               if (idx == '0) state <= SAR_DONE;
               else           idx   <= idx - 1'b1;
            end
            default: begin
               code  <= sar;
               eoc   <= 1'b1;
               busy  <= 1'b0;
               state <= SAR_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/spi_sar_adc_slave.sv
// SPI mode-0 SAR ADC responder: cs_n fall starts a conversion whose result leaves on MISO in the same frame.
// Latency: SYNC_STAGES+1 clk from pin edge to action; no backpressure, the master paces everything.
module spi_sar_adc_slave
   import spi_adc_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [DATA_W-1:0]  analog_volts,
   input  logic               sclk,
   input  logic               cs_n,
   input  logic               mosi,
   output logic               miso,
   output logic               miso_oe,
   output logic               busy,
   output logic               eoc,
   output logic [DATA_W-1:0]  last_code,
   output logic [FRAME_W-1:0] rx_word,
   output logic               rx_valid,
   output logic               ovr
);

   localparam int CNT_W = $clog2(FRAME_W + 2);
   localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(FRAME_W - DATA_W - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0] OVER_CNT = CNT_W'(FRAME_W + 1);

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic                   sclk_d, cs_d;
   logic                   sclk_s, cs_s, mosi_s;
   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

   logic [DATA_W-1:0]      tx_sh;
   logic [FRAME_W-1:0]     rx_shift;
   logic [CNT_W-1:0]       fall_cnt, rise_cnt;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_rise   = cs_s & ~cs_d;
   assign cs_fall   = ~cs_s & cs_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
         cs_sync   <= {SYNC_STAGES{CS_N_IDLE}};
         mosi_sync <= {SYNC_STAGES{MOSI_IDLE}};
         sclk_d    <= SCLK_IDLE;
         cs_d      <= CS_N_IDLE;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;
      end
   end

   sar_core u_sar (
      .clk     (clk),
      .rst     (rst),
      .start   (cs_fall),
      .held_in (analog_volts),
      .busy    (busy),
      .eoc     (eoc),
      .code    (last_code)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         miso     <= 1'b0;
         miso_oe  <= 1'b0;
         ovr      <= 1'b0;
         rx_word  <= '0;
         rx_valid <= 1'b0;
         tx_sh    <= '0;
         rx_shift <= '0;
         fall_cnt <= '0;
         rise_cnt <= '0;
      end else begin
         rx_valid <= 1'b0;
         if (cs_fall) begin
            miso_oe  <= 1'b1;
            miso     <= 1'b0;
            ovr      <= 1'b0;
            tx_sh    <= '0;
            fall_cnt <= '0;
            rise_cnt <= '0;
         end else if (cs_rise) begin
            miso_oe <= 1'b0;
            miso    <= 1'b0;
            if (rise_cnt == FULL_CNT) begin
               rx_word  <= rx_shift;
               rx_valid <= 1'b1;
            end
         end else if (!cs_s) begin
            if (sclk_fall) begin
               if (fall_cnt != FULL_CNT) fall_cnt <= fall_cnt + 1'b1;
               // fall_cnt is the count before this edge, so LOAD_CNT presents result bit DATA_W-1
               if (fall_cnt < LOAD_CNT) begin
                  miso <= 1'b0;
               end else if (fall_cnt == LOAD_CNT) begin
                  if (busy) begin
                     ovr   <= 1'b1;
                     miso  <= 1'b0;
                     tx_sh <= '0;
                  end else begin
                     miso  <= last_code[DATA_W-1];
                     tx_sh <= {last_code[DATA_W-2:0], 1'b0};
                  end
               end else if (fall_cnt < LAST_CNT) begin
                  miso  <= tx_sh[DATA_W-1];
                  tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
               end else begin
                  miso <= 1'b0;
               end
            end
            if (sclk_rise) begin
               rx_shift <= {rx_shift[FRAME_W-2:0], mosi_s};
               if (rise_cnt != OVER_CNT) rise_cnt <= rise_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_sar_adc_slave.sv
// Directed bench for spi_sar_adc_slave: drives SPI frames and compares against hand-computed values.
module tb_spi_sar_adc_slave;
   import spi_adc_pkg::*;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [DATA_W-1:0]  analog_volts = '0;
   logic               sclk = 1'b0;
   logic               cs_n = 1'b1;
   logic               mosi = 1'b0;
   logic               miso, miso_oe, busy, eoc, rx_valid, ovr;
   logic [DATA_W-1:0]  last_code;
   logic [FRAME_W-1:0] rx_word;

   int checks = 0;
   int errors = 0;
   int eoc_cnt = 0, rxv_cnt = 0, conv_cnt = 0, miso_hi_cnt = 0;
   int eoc0, rxv0, conv0, hi0;
   logic [15:0] rd;

   always #5 clk = ~clk;

   spi_sar_adc_slave dut (
      .clk          (clk),
      .rst          (rst),
      .analog_volts (analog_volts),
      .sclk         (sclk),
      .cs_n         (cs_n),
      .mosi         (mosi),
      .miso         (miso),
      .miso_oe      (miso_oe),
      .busy         (busy),
      .eoc          (eoc),
      .last_code    (last_code),
      .rx_word      (rx_word),
      .rx_valid     (rx_valid),
      .ovr          (ovr)
   );

   always @(negedge clk) begin
      if (eoc) eoc_cnt++;
      if (rx_valid) rxv_cnt++;
      if (dut.u_sar.state == SAR_CONVERT) conv_cnt++;
      if (miso) miso_hi_cnt++;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic snap();
      eoc0 = eoc_cnt; rxv0 = rxv_cnt; conv0 = conv_cnt; hi0 = miso_hi_cnt;
   endtask

   task automatic wait_busy();
      for (int n = 0; n < 100 && !busy; n++) @(negedge clk);
      check_val("busy_seen", {31'd0, busy}, 32'd1);
   endtask

   // Master side of one frame: MISO is sampled just before each rising SCLK edge.
   task automatic spi_frame(input logic [15:0] tx, input int half, input int nedge,
                            output logic [15:0] rx);
      rx = '0;
      @(negedge clk);
      cs_n = 1'b0;
      for (int k = 0; k < nedge; k++) begin
         mosi = (k < 16) ? tx[15-k] : 1'b0;
         repeat (half) @(negedge clk);
         rx = {rx[14:0], miso};
         sclk = 1'b1;
         repeat (half) @(negedge clk);
         sclk = 1'b0;
      end
      repeat (half) @(negedge clk);
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_val("rst_outs", {26'd0, miso, miso_oe, busy, eoc, rx_valid, ovr}, 32'd0);
      check_val("rst_code", {20'd0, last_code}, 32'd0);
      check_val("rst_rxw", {16'd0, rx_word}, 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Nominal frame
      analog_volts = 12'd2500;
      snap();
      spi_frame(16'hA5C3, 10, 16, rd);
      check_val("f1_miso", {16'd0, rd}, 32'h09C4);
      check_val("f1_code", {20'd0, last_code}, 32'd2500);
      check_val("f1_eoc", eoc_cnt - eoc0, 1);
      check_val("f1_rxw", {16'd0, rx_word}, 32'hA5C3);
      check_val("f1_rxv", rxv_cnt - rxv0, 1);
      check_val("f1_ovr", {31'd0, ovr}, 32'd0);
      check_val("f1_oe", {31'd0, miso_oe}, 32'd0);

      // Back-to-back extremes
      analog_volts = 12'd0;
      snap();
      spi_frame(16'h1234, 10, 16, rd);
      check_val("zero_miso", {16'd0, rd}, 32'h0000);
      check_val("zero_conv", conv_cnt - conv0, 12);
      check_val("zero_rxw", {16'd0, rx_word}, 32'h1234);
      analog_volts = 12'd4095;
      snap();
      spi_frame(16'hBEEF, 10, 16, rd);
      check_val("full_miso", {16'd0, rd}, 32'h0FFF);
      check_val("full_conv", conv_cnt - conv0, 12);
      check_val("full_rxw", {16'd0, rx_word}, 32'hBEEF);

      // Aborted frame after 7 edges
      analog_volts = 12'd1234;
      snap();
      spi_frame(16'hFFFF, 10, 7, rd);
      repeat (20) @(negedge clk);
      check_val("abort_rxv", rxv_cnt - rxv0, 0);
      check_val("abort_rxw", {16'd0, rx_word}, 32'hBEEF);
      check_val("abort_code", {20'd0, last_code}, 32'd1234);
      check_val("abort_oe", {31'd0, miso_oe}, 32'd0);

      // SCLK far too fast: result not ready at the load edge
      analog_volts = 12'd4095;
      snap();
      spi_frame(16'h5A5A, 1, 16, rd);
      repeat (30) @(negedge clk);
      check_val("fast_ovr", {31'd0, ovr}, 32'd1);
      check_val("fast_miso_hi", miso_hi_cnt - hi0, 0);
      check_val("fast_code", {20'd0, last_code}, 32'd4095);

      analog_volts = 12'd2048;
      spi_frame(16'h0F0F, 10, 16, rd);
      check_val("clr_ovr", {31'd0, ovr}, 32'd0);
      check_val("clr_miso", {16'd0, rd}, 32'h0800);
      check_val("clr_rxw", {16'd0, rx_word}, 32'h0F0F);

      // Extra edges past the frame length
      snap();
      spi_frame(16'hFFFF, 10, 18, rd);
      check_val("extra_rxv", rxv_cnt - rxv0, 0);
      check_val("extra_rxw", {16'd0, rx_word}, 32'h0F0F);

      // Reset during conversion bit 5
      analog_volts = 12'd1500;
      snap();
      @(negedge clk);
      cs_n = 1'b0;
      wait_busy();
      repeat (6) @(negedge clk);
      rst  = 1'b1;
      cs_n = 1'b1;
      @(negedge clk);
      check_val("mrst_outs", {26'd0, miso, miso_oe, busy, eoc, rx_valid, ovr}, 32'd0);
      check_val("mrst_code", {20'd0, last_code}, 32'd0);
      check_val("mrst_rxw", {16'd0, rx_word}, 32'd0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check_val("mrst_eoc", eoc_cnt - eoc0, 0);
      check_val("mrst_busy", {31'd0, busy}, 32'd0);
      analog_volts = 12'd3000;
      spi_frame(16'h00C3, 10, 16, rd);
      check_val("post_rst_miso", {16'd0, rd}, 32'h0BB8);
      check_val("post_rst_code", {20'd0, last_code}, 32'd3000);

      // Sample-and-hold: input moves during CONVERT
      analog_volts = 12'd100;
      fork
         spi_frame(16'h3C3C, 10, 16, rd);
         begin
            wait_busy();
            repeat (3) @(negedge clk);
            analog_volts = 12'd3000;
         end
      join
      check_val("hold_miso", {16'd0, rd}, 32'h0064);
      check_val("hold_code", {20'd0, last_code}, 32'd100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_sar_adc_slave.md
Name: spi_sar_adc_slave

Overview:
- SPI mode-0 responder modelling the SAR ADC at the far end of the SoC's SPI master.
- Chip-select falling edge samples `analog_volts` and runs a 12-step successive-approximation conversion on `clk`.
- The 12-bit result is shifted out on MISO in the same frame. MOSI is captured as a 16-bit command word.
- Sits beside `soc_adc` as the device model or on-chip ADC front end.

Parameters:
- DATA_W, 12, ADC resolution and result width.
- FRAME_W, 16, SCLK edges per frame (4 leading zero bits, then DATA_W result bits).
- SYNC_STAGES, 2, synchroniser depth for sclk, cs_n and mosi.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- analog_volts  in  DATA_W  digitised analog input (sampled-and-held at frame start)
- sclk  in  1  SPI clock from master, asynchronous to clk
- cs_n  in  1  SPI chip select, active-low
- mosi  in  1  SPI data in
- miso  out  1  SPI data out
- miso_oe  out  1  MISO output enable (1 while selected)
- busy  out  1  SAR conversion in progress
- eoc  out  1  one-clk pulse at end of conversion
- last_code  out  DATA_W  most recent completed conversion
- rx_word  out  FRAME_W  last complete MOSI word
- rx_valid  out  1  one-clk pulse when rx_word updates
- ovr  out  1  sticky: result bits were shifted before conversion finished

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. All outputs are 0, FSM is in IDLE, and the synchronisers are cleared to idle values (sclk=0, cs_n=1, mosi=0).
- sclk, cs_n and mosi pass through SYNC_STAGES flops. Edges are detected in the clk domain.
- Timing requirement: SCLK half-period ≥ 4 clk. The bench must honour this, and the RTL need not handle faster SCLK.

SAR FSM, states IDLE → SAMPLE → CONVERT → DONE → IDLE:
- IDLE: a synced cs_n fall moves to SAMPLE at cycle T.
- SAMPLE (T): latch held = analog_volts, clear sar to 0, set bit index i = DATA_W-1, raise busy.
- CONVERT (T+1 .. T+DATA_W): each cycle, trial = sar | (1<<i). If held ≥ trial (unsigned), sar = trial. Then decrement i. Leave after i = 0.
- DONE (T+DATA_W+1): last_code = sar, eoc = 1 for one cycle, busy = 0, return to IDLE.
- The result equals held exactly. Example: 2500 → 0x9C4.
- A cs_n fall while not in IDLE is ignored for conversion. The shift logic still restarts.

SPI shifter, mode 0 (master samples on rising edge, slave drives on falling edge):
- On a cs_n fall: miso_oe = 1, bit counter = 0, miso = 0 (frame bit FRAME_W-1), ovr cleared.
- On each synced sclk fall with cs_n low: the counter increments and miso presents frame bit FRAME_W-1-counter.
  - Frame bits FRAME_W-1 .. DATA_W are 0.
  - Frame bits DATA_W-1 .. 0 are the result bits MSB-first.
- At the falling edge that presents result bit DATA_W-1, the tx register loads last_code.
  - If busy is still 1 at that point, set ovr and shift 0s for the result bits.
- On each synced sclk rise with cs_n low: shift mosi into rx_shift (MSB first) and count rising edges.
- On a cs_n rise:
  - miso_oe = 0, miso = 0.
  - If exactly FRAME_W rising edges were counted: rx_word = rx_shift and rx_valid pulses for one cycle.
  - Otherwise (aborted frame) rx_word is unchanged and there is no pulse.
- Extra SCLK edges beyond FRAME_W: miso holds 0 and rx is not updated.
- cs_n rising mid-conversion does not stop the conversion. last_code and eoc still update.
- Reset mid-frame or mid-conversion returns everything to reset values immediately. A partial frame is never reported.

Decomposition:
- Package `spi_adc_pkg` holds DATA_W, FRAME_W, the SAR state enum (IDLE, SAMPLE, CONVERT, DONE) and the synchroniser default values.
- Sub-module `sar_core`: the SAR FSM with ports clk, rst, start, held_in, busy, eoc, code.
- The top level holds the synchronisers and SPI shift/receive logic.

Test Plan:
- analog_volts = 2500, one 16-bit frame at SCLK half-period 10 clk, MOSI = 0xA5C3 → MISO bits read as 0x09C4, last_code = 2500, eoc pulses once, rx_word = 0xA5C3, rx_valid pulses once, ovr = 0.
- analog_volts = 0, then 4095 in back-to-back frames → MISO reads 0x0000, then 0x0FFF, with exactly 12 CONVERT cycles each.
- cs_n raised after 7 SCLK edges with analog_volts = 1234 → rx_valid stays 0, rx_word is unchanged, last_code = 1234 after conversion completes, miso_oe = 0.
- SCLK half-period 1 clk (timing violation forced) → ovr = 1 and result bits are 0. The next valid-speed frame clears ovr.
- rst asserted at conversion bit 5 → busy = 0, eoc never pulses, all outputs are 0. A following normal frame with 3000 returns 0x0BB8.
- analog_volts changes from 100 to 3000 during CONVERT → result = 100, confirming the sample-and-hold.
